// File: rtl/full_subtractor_checker.sv
// On-chip exerciser for a 1-bit full subtractor: walks all eight {a,b,bin} vectors,
// compares each response against a golden table and records the error count and first failure.
module full_subtractor_checker #(
  parameter int unsigned SETTLE = 1  // cycles each vector is held before sampling, 1..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  output logic       dut_bin,
  input  logic       dut_diff,
  input  logic       dut_bout,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       fail_valid,
  output logic [2:0] first_fail
);

  typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

  localparam logic [3:0] SettleLoad = 4'(SETTLE - 1);

  state_e     state_q;
  logic [2:0] idx_q;
  logic [3:0] settle_cnt_q;
  logic [1:0] golden;
  logic       mismatch;
  logic [3:0] err_next;

  // Expected {diff,bout} for each {a,b,bin}.
  always_comb begin
    golden = 2'b00;
    unique case (idx_q)
      3'd0: golden = 2'b00;
      3'd1: golden = 2'b11;
      3'd2: golden = 2'b11;
      3'd3: golden = 2'b01;
      3'd4: golden = 2'b10;
      3'd5: golden = 2'b00;
      3'd6: golden = 2'b00;
      3'd7: golden = 2'b11;
      default: golden = 2'b00;
    endcase
  end

  assign mismatch = ({dut_diff, dut_bout} != golden);
  assign err_next = err_count + {3'd0, mismatch};

  // The stimulus is the vector index itself, so it holds 7 after a run.
  assign {dut_a, dut_b, dut_bin} = idx_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      idx_q        <= 3'd0;
      settle_cnt_q <= 4'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_count    <= 4'd0;
      fail_valid   <= 1'b0;
      first_fail   <= 3'd0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            err_count    <= 4'd0;
            fail_valid   <= 1'b0;
            first_fail   <= 3'd0;
            pass         <= 1'b0;
            idx_q        <= 3'd0;
            settle_cnt_q <= SettleLoad;
            busy         <= 1'b1;
            state_q      <= StSettle;
          end
        end
        StSettle: begin
          if (settle_cnt_q == 4'd0) begin
            state_q <= StCheck;
          end else begin
            settle_cnt_q <= settle_cnt_q - 4'd1;
          end
        end
        StCheck: begin
          err_count <= err_next;
          if (mismatch && !fail_valid) begin
            fail_valid <= 1'b1;
            first_fail <= idx_q;
          end
          if (idx_q == 3'd7) begin
            // Verdict is taken on entry so it is already stable in the done cycle.
            done    <= 1'b1;
            pass    <= (err_next == 4'd0);
            state_q <= StDone;
          end else begin
            idx_q        <= idx_q + 3'd1;
            settle_cnt_q <= SettleLoad;
            state_q      <= StSettle;
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_full_subtractor_checker.sv
// Bench for full_subtractor_checker: two instances (SETTLE=1 and SETTLE=3) each driving a
// behavioural subtractor with selectable faults; results checked against an arithmetic reference.
module tb_full_subtractor_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start1, start3;
  int   mode;  // 0 correct, 1 diff stuck 0, 2 wrong bout, 3 random flips
  logic [1:0] mask [8];

  logic a1, b1, bin1, diff1, bout1, busy1, done1, pass1, fv1;
  logic [3:0] err1;
  logic [2:0] ff1;
  logic a3, b3, bin3, diff3, bout3, busy3, done3, pass3, fv3;
  logic [3:0] err3;
  logic [2:0] ff3;

  int n_checks = 0;
  int n_fail   = 0;

  full_subtractor_checker #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .dut_a(a1), .dut_b(b1), .dut_bin(bin1), .dut_diff(diff1), .dut_bout(bout1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fv1), .first_fail(ff1)
  );

  full_subtractor_checker #(.SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .dut_a(a3), .dut_b(b3), .dut_bin(bin3), .dut_diff(diff3), .dut_bout(bout3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .fail_valid(fv3), .first_fail(ff3)
  );

  // Subtractor under test, with optional faults; returns {diff,bout}.
  function automatic logic [1:0] model_resp(input int m, input logic a, input logic b,
                                            input logic bin, input logic [1:0] msk);
    logic d, bo;
    d  = a ^ b ^ bin;
    bo = (~a & b) | (~(a ^ b) & bin);
    if (m == 1) d = 1'b0;
    if (m == 2) bo = (a & ~b) | (~(a ^ b) & bin);
    if (m == 3) {d, bo} = {d, bo} ^ msk;
    return {d, bo};
  endfunction

  always_comb {diff1, bout1} = model_resp(mode, a1, b1, bin1, mask[{a1, b1, bin1}]);
  always_comb {diff3, bout3} = model_resp(mode, a3, b3, bin3, mask[{a3, b3, bin3}]);

  // Reference: a - b - bin as a signed integer; low bit is diff, sign is borrow.
  function automatic logic [1:0] ref_sub(input int v);
    int r;
    r = ((v >> 2) & 1) - ((v >> 1) & 1) - (v & 1);
    return {((r & 1) != 0), (r < 0)};
  endfunction

  typedef struct {
    logic [2:0] vec;
    logic       busy, done, pass, fv;
    logic [3:0] err;
    logic [2:0] ff;
  } obs_t;

  function automatic obs_t get_obs(input bit sel);
    obs_t o;
    if (sel) begin
      o.vec = {a3, b3, bin3}; o.busy = busy3; o.done = done3; o.pass = pass3;
      o.fv = fv3; o.err = err3; o.ff = ff3;
    end else begin
      o.vec = {a1, b1, bin1}; o.busy = busy1; o.done = done1; o.pass = pass1;
      o.fv = fv1; o.err = err1; o.ff = ff1;
    end
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) start3 = v;
    else start1 = v;
  endtask

  task automatic chk_reset_vals(input bit sel, input string tag);
    obs_t o;
    o = get_obs(sel);
    chk({tag, "_vec"}, 32'(o.vec), 32'd0);
    chk({tag, "_busy"}, 32'(o.busy), 32'd0);
    chk({tag, "_done"}, 32'(o.done), 32'd0);
    chk({tag, "_pass"}, 32'(o.pass), 32'd0);
    chk({tag, "_err"}, 32'(o.err), 32'd0);
    chk({tag, "_fv"}, 32'(o.fv), 32'd0);
    chk({tag, "_ff"}, 32'(o.ff), 32'd0);
  endtask

  // Entered and left just after a falling edge. Launch is sampled at the next rising edge (k).
  task automatic run(input bit sel, input int settle, input bit restart, input int rst_at);
    obs_t o;
    int   n, exp_err, exp_ff, exp_vec, done_seen;
    bit   exp_fv;
    exp_err = 0; exp_ff = 0; exp_fv = 0;
    for (int v = 0; v < 8; v++) begin
      logic [2:0] vv;
      vv = v[2:0];
      if (model_resp(mode, vv[2], vv[1], vv[0], mask[v]) !== ref_sub(v)) begin
        if (!exp_fv) exp_ff = v;
        exp_fv = 1'b1;
        exp_err++;
      end
    end
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    n = 1;
    o = get_obs(sel);
    chk("launch_busy", 32'(o.busy), 32'd1);
    chk("launch_pass_clr", 32'(o.pass), 32'd0);
    chk("launch_fv_clr", 32'(o.fv), 32'd0);
    while (n < 200) begin
      o = get_obs(sel);
      exp_vec = (n - 1) / (settle + 1);
      if (exp_vec > 7) exp_vec = 7;
      chk("vector", 32'(o.vec), 32'(exp_vec));
      if (o.done) break;
      set_start(sel, (restart && n == 5) ? 1'b1 : 1'b0);
      if (n == rst_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_reset_vals(sel, "midrun_rst");
        done_seen = 0;
        repeat (40) begin
          @(negedge clk);
          if (get_obs(sel).done) done_seen++;
        end
        chk("no_done_after_rst", 32'(done_seen), 32'd0);
        chk("idle_after_rst", 32'(get_obs(sel).busy), 32'd0);
        return;
      end
      @(negedge clk);
      n++;
    end
    chk("done_cycle", 32'(n), 32'(8 * (settle + 1) + 1));
    chk("pass", 32'(o.pass), 32'(exp_err == 0));
    chk("err_count", 32'(o.err), 32'(exp_err));
    chk("fail_valid", 32'(o.fv), 32'(exp_fv));
    if (exp_fv) chk("first_fail", 32'(o.ff), 32'(exp_ff));
    @(negedge clk);
    o = get_obs(sel);
    chk("busy_after_done", 32'(o.busy), 32'd0);
    chk("done_pulse_1cyc", 32'(o.done), 32'd0);
    chk("pass_held", 32'(o.pass), 32'(exp_err == 0));
    chk("err_held", 32'(o.err), 32'(exp_err));
    chk("vec_held", 32'(o.vec), 32'd7);
  endtask

  initial begin
    rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; mode = 0;
    for (int i = 0; i < 8; i++) mask[i] = 2'b00;
    repeat (3) @(negedge clk);
    chk_reset_vals(1'b0, "reset1");
    chk_reset_vals(1'b1, "reset3");
    rst_n = 1'b1;
    @(negedge clk);

    // Correct DUT, then each directed fault; runs are back-to-back.
    run(1'b0, 1, 1'b0, 0);
    mode = 1;
    run(1'b0, 1, 1'b0, 0);
    chk("stuck_diff_err", 32'(err1), 32'd4);
    chk("stuck_diff_ff", 32'(ff1), 32'd1);
    mode = 2;
    run(1'b0, 1, 1'b0, 0);
    chk("bad_bout_err", 32'(err1), 32'd4);
    chk("bad_bout_ff", 32'(ff1), 32'd2);

    // Ignored restart, mid-run reset, then a clean run.
    mode = 0;
    run(1'b0, 1, 1'b1, 0);
    run(1'b0, 1, 1'b0, 9);
    run(1'b0, 1, 1'b0, 0);
    chk("clean_after_rst_pass", 32'(pass1), 32'd1);

    // Longer settle time.
    run(1'b1, 3, 1'b0, 0);
    mode = 1;
    run(1'b1, 3, 1'b0, 0);

    // Random response flips on both instances.
    mode = 3;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 8; i++)
        mask[i] = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run(r[0], r[0] ? 3 : 1, 1'b0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
